fetch_ctrl: RTL
===============

# fetch_ctrl

Fetch-side counterpart of the ID-stage branch hazard unit. It owns the PC register and the IF/ID pipeline register and obeys the stall controls that unit drives (PC write enable, IF/ID write enable). It also applies the one-slot squash when a branch resolved in ID is taken. A small state machine tracks run/stall/redirect, keeps saturating stall/flush statistics, and flags stalls longer than the hazard protocol can legally produce.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of statistics counters
- MAX_STALL, 3, consecutive stall cycles that raise stall_timeout

- clk  in  1  pipeline clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- pc_write  in  1  1 = PC may advance; 0 = hold (from hazard unit)
- ifid_write  in  1  1 = IF/ID may load; 0 = hold (from hazard unit)
- branch_taken  in  1  ID-stage branch resolved taken this cycle
- branch_target  in  32  ID-stage branch target
- imem_rdata  in  32  instruction at imem_addr, same cycle (async imem)
- imem_addr  out  32  current PC (registered)
- ifid_instr  out  32  instruction presented to ID
- ifid_pc4  out  32  PC+4 of that instruction
- ifid_valid  out  1  0 = ID slot holds a squashed NOP
- state  out  2  RUN=0, STALL=1, REDIRECT=2
- stall_cnt  out  CNT_W  cycles with pc_write=0, saturating
- flush_cnt  out  CNT_W  taken-branch squashes, saturating
- stall_timeout  out  1  sticky, consecutive stalls reached MAX_STALL
- protocol_err  out  1  sticky, pc_write=1 while ifid_write=0

## Operation
- Reset values: PC=PC_RESET; ifid_instr=0, ifid_pc4=0, ifid_valid=0; state=RUN; counters=0; stall_timeout=0, protocol_err=0. An asserted rst aborts any in-progress stall or redirect immediately.
- PC update priority:
  - pc_write=0: hold; branch_taken is ignored. The hazard unit re-presents the branch after the stall.
  - pc_write=1 and branch_taken: PC<=branch_target.
  - Otherwise: PC<=PC+4, mod 2^32; wraps from 0xFFFF_FFFC to 0.
- IF/ID update:
  - pc_write=1 and branch_taken: ifid_instr<=0 (NOP), ifid_valid<=0, ifid_pc4<=PC+4. The squash overrides ifid_write.
  - Else ifid_write=1: ifid_instr<=imem_rdata, ifid_pc4<=PC+4, ifid_valid<=1.
  - Else hold.
- Mismatched enables:
  - pc_write=0, ifid_write=1: legal; IF/ID reloads the same instruction.
  - pc_write=1, ifid_write=0: the advance still happens and protocol_err sets.
- FSM, next state:
  - pc_write=1 and branch_taken: REDIRECT, from any state.
  - Else pc_write=0: STALL.
  - Else: RUN.
  - REDIRECT lasts exactly one cycle unless a second taken branch follows.
- Statistics:
  - stall_cnt +1 per cycle with pc_write=0.
  - flush_cnt +1 per squash.
  - Both saturate at 2^CNT_W-1.
- Timeout: a consecutive-stall counter resets to 0 on any pc_write=1. stall_timeout sets when it reaches MAX_STALL. Cleared only by rst.

## Timing
- imem_addr is a registered output, valid from posedge.
- imem_rdata is sampled at the same posedge that advances the PC.
- Fetch latency: an instruction at PC enters ID one cycle after PC appears on imem_addr.
- Taken-branch penalty is 1 cycle. branch_taken high at edge N gives:
  - imem_addr=target after N.
  - NOP (valid=0) in ID after N.
  - Target instruction in ID after N+1.
- Load-use branch (two stall cycles, pc_write=0 twice) must not raise stall_timeout at default MAX_STALL=3.
- No combinational path from inputs to outputs.

## Structure
- Shared pipeline package holds:
  - state encoding (RUN/STALL/REDIRECT)
  - NOP_INSTR=32'h0
  - PC_INC=4
- One sub-module is natural: sat_counter (parameterised width, enable, async reset), instantiated for stall_cnt, flush_cnt and the consecutive-stall counter.

## Test plan
- Reset, then 3 cycles with pc_write=ifid_write=1 and imem_rdata=0x11,0x22,0x33 -> imem_addr 0,4,8,12; ifid_instr 0x11,0x22,0x33; ifid_pc4 4,8,12; valid=1.
- With PC=0x10, assert branch_taken with target 0x40 for one cycle -> imem_addr=0x40, ifid_instr=0, valid=0, flush_cnt=1, state=REDIRECT; next cycle ID gets imem_rdata fetched at 0x40 and state=RUN.
- pc_write=ifid_write=0 for 2 cycles at PC=0x20 -> PC and IF/ID frozen, state=STALL, stall_cnt=2, stall_timeout=0. A 3rd consecutive stall sets stall_timeout.
- pc_write=0 with branch_taken=1 (target 0x80), then pc_write=1 with branch_taken=1 -> no redirect in the stalled cycle; PC=0x80 after the second cycle.
- pc_write=1, ifid_write=0 for one cycle -> protocol_err=1 and stays set; PC advances by 4; IF/ID unchanged.
- Assert rst mid-STALL with counters nonzero -> all outputs return to reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: FSM encoding and fixed instruction constants.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } fetch_state_e;

    // All-zero word injected into ID when a slot is squashed.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    // Sequential fetch step (one 32-bit instruction).
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// Clear wins over enable; once all ones, the counter holds.
module fetch_ctrl_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear, increment unless saturated, or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC register, IF/ID register, taken-branch squash,
// run/stall/redirect tracking, stall/flush statistics and protocol checks.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter int          CNT_W     = 16,
    parameter int          MAX_STALL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_write,
    input  logic             ifid_write,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             stall_timeout,
    output logic             protocol_err
);

    // Wide enough to hold MAX_STALL so the run length can saturate there.
    localparam int CONS_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [CONS_W-1:0] TO_THRESH = CONS_W'(MAX_STALL - 1);

    logic [31:0]  pc_q,         pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc4_q,   ifid_pc4_d;
    logic         ifid_valid_q, ifid_valid_d;
    fetch_state_e state_q,      state_d;
    logic         timeout_q,    timeout_d;
    logic         perr_q,       perr_d;

    logic              squash;
    logic              stalled;
    logic [31:0]       pc_plus4;
    logic [CONS_W-1:0] consec_cnt;

    assign squash   = pc_write & branch_taken;
    assign stalled  = ~pc_write;
    assign pc_plus4 = pc_q + PC_INC;

    // Next PC, IF/ID contents, FSM state and sticky error flags.
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        state_d      = ST_RUN;
        timeout_d    = timeout_q;
        perr_d       = perr_q;

        // A stalled PC ignores branch_taken; the hazard unit re-presents it.
        if (squash) begin
            pc_d = branch_target;
        end else if (pc_write) begin
            pc_d = pc_plus4;
        end

        // Squash overrides ifid_write so the wrong-path fetch never reaches ID.
        if (squash) begin
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b0;
        end else if (ifid_write) begin
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
        end

        if (squash) begin
            state_d = ST_REDIRECT;
        end else if (stalled) begin
            state_d = ST_STALL;
        end

        // Advancing PC while IF/ID holds would lose an instruction.
        if (pc_write && !ifid_write) begin
            perr_d = 1'b1;
        end

        // Flag on the stall cycle that brings the run length to MAX_STALL.
        if (stalled && (consec_cnt >= TO_THRESH)) begin
            timeout_d = 1'b1;
        end
    end

    // Pipeline and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= PC_RESET;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
            state_q      <= ST_RUN;
            timeout_q    <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            state_q      <= state_d;
            timeout_q    <= timeout_d;
            perr_q       <= perr_d;
        end
    end

    fetch_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (stalled),
        .count (stall_cnt)
    );

    fetch_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (squash),
        .count (flush_cnt)
    );

    // Length of the current run of stall cycles.
    fetch_ctrl_sat_counter #(.W(CONS_W)) u_consec_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (pc_write),
        .en    (stalled),
        .count (consec_cnt)
    );

    assign imem_addr     = pc_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_pc4      = ifid_pc4_q;
    assign ifid_valid    = ifid_valid_q;
    assign state         = state_q;
    assign stall_timeout = timeout_q;
    assign protocol_err  = perr_q;

endmodule
